blit_outer_seq: RTL

BLIT_OUTER_SEQ -- requirements
Module: blit_outer_seq

---
 rtl/blit_outer_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/blit_outer_seq.sv
// Outer-loop sequencer for the blitter: loads the external outer counter, runs the inner loop once per count, then signals done.
// Optional iteration counter on iter_cnt is built only when BLIT_OUTER_ITER_CNT_EN is defined.
module blit_outer_seq #(
    parameter int LD_SETTLE = 1,
    parameter int ITER_W    = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              outer0,
    input  logic              inner_done,
    output logic              countld,
    output logic              ocntena,
    output logic              inner_go,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        INNER,
        STEP,
        DONE
    } state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(LD_SETTLE - 1);

    state_t     state;
    logic [2:0] wait_cnt;
    logic       kill;

    assign kill = abort && (state != IDLE);

    // Outputs are registered for the state being entered, so each pulse lines up with its state.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            countld  <= 1'b0;
            ocntena  <= 1'b0;
            inner_go <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            countld  <= 1'b0;
            ocntena  <= 1'b0;
            inner_go <= 1'b0;
            done     <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= LOAD;
                            countld <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    LOAD: begin
                        state    <= SETTLE;
                        wait_cnt <= SETTLE_LAST;
                    end
                    SETTLE: begin
                        if (wait_cnt == 3'd0) begin
                            state <= CHECK;
                        end else begin
                            wait_cnt <= wait_cnt - 3'd1;
                        end
                    end
                    CHECK: begin
                        if (outer0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= INNER;
                            inner_go <= 1'b1;
                        end
                    end
                    INNER: begin
                        if (inner_done) begin
                            state   <= STEP;
                            ocntena <= 1'b1;
                        end
                    end
                    STEP: begin
                        state    <= SETTLE;
                        wait_cnt <= SETTLE_LAST;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BLIT_OUTER_ITER_CNT_EN
    // Cleared as LOAD is entered, bumped as STEP is entered, held otherwise.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            iter_cnt <= '0;
        end else if (!kill) begin
            if (state == IDLE && start) begin
                iter_cnt <= '0;
            end else if (state == INNER && inner_done) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
            end
        end
    end
`else
    assign iter_cnt = '0;
`endif

endmodule
